anfsqrt_seq: RTL

ANFSQRT_SEQ -- requirements
Module: anfsqrt_seq

---
 rtl/anfsqrt_seq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/anfsqrt_seq.sv
// Sequential integer square root: floor(sqrt(in_arg)) and remainder using
// a shift/subtract recurrence on a one-hot attempt bit. ITERS recurrence
// steps are chained combinationally per clock; EARLY_START skips leading
// zero bit-pairs of the radicand.
module anfsqrt_seq #(
    parameter int ITERS       = 1,
    parameter int EARLY_START = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_arg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_root,
    output logic [16:0] out_rem,
    output logic [4:0]  out_cycles,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One recurrence state: one-hot attempt bit, running remainder, partial root.
    typedef struct packed {
        logic [16:0] att;
        logic [31:0] eps;
        logic [15:0] res;
    } step_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [16:0] att_r;
    logic [31:0] eps_r;
    logic [15:0] res_r;
    logic [4:0]  cnt_r;
    logic [15:0] out_root_r;
    logic [16:0] out_rem_r;
    logic [4:0]  out_cycles_r;
    logic [4:0]  k_s;
    step_t       chain_s;
    logic        last_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        busy_s;

    // Index of the highest set bit of a 32-bit word (0 for a zero word).
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    // Bit position of a one-hot 17-bit attempt value.
    function automatic logic [4:0] onehot_log2(input logic [16:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (v[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    // One recurrence step; an exhausted attempt bit (<=1) passes through so
    // later chained stages never operate on a zero attempt bit.
    function automatic step_t iter_step(input step_t s);
        step_t       r;
        logic [16:0] att_n;
        logic [4:0]  a;
        logic [31:0] delta;
        r = s;
        if (s.att > 17'd1) begin
            att_n = s.att >> 1;
            a     = onehot_log2(att_n);
            delta = ({16'd0, s.res} << (a + 5'd1)) + (32'd1 << {a, 1'b0});
            r.att = att_n;
            if (delta <= s.eps) begin
                r.eps = s.eps - delta;
                r.res = s.res | att_n[15:0];
            end else begin
                r.eps = s.eps;
                r.res = s.res;
            end
        end else begin
            r = s;
        end
        return r;
    endfunction

    // ITERS steps applied in series within one clock.
    function automatic step_t run_chain(input step_t s);
        step_t r;
        r = s;
        for (int i = 0; i < ITERS; i++) begin
            r = iter_step(r);
        end
        return r;
    endfunction

    // Starting attempt exponent: full 16 steps, or just above the radicand's top bit-pair.
    always_comb begin
        k_s = 5'd16;
        if (EARLY_START != 0) begin
            k_s = {1'b0, msb_index(in_arg) >> 1} + 5'd1;
        end else begin
            k_s = 5'd16;
        end
    end

    // Combinational iteration chain fed from the registered recurrence state.
    always_comb begin
        chain_s = run_chain('{att: att_r, eps: eps_r, res: res_r});
        last_s  = (chain_s.att == 17'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            S_IDLE:  in_ready_s = !rst;
            S_RUN:   busy_s = 1'b1;
            S_DONE: begin
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Recurrence registers, RUN cycle counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            att_r        <= 17'd0;
            eps_r        <= 32'd0;
            res_r        <= 16'd0;
            cnt_r        <= 5'd0;
            out_root_r   <= 16'd0;
            out_rem_r    <= 17'd0;
            out_cycles_r <= 5'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        att_r <= 17'd1 << k_s;
                        eps_r <= in_arg;
                        res_r <= 16'd0;
                        cnt_r <= 5'd0;
                    end else begin
                        att_r <= att_r;
                    end
                end
                S_RUN: begin
                    att_r <= chain_s.att;
                    eps_r <= chain_s.eps;
                    res_r <= chain_s.res;
                    cnt_r <= cnt_r + 5'd1;
                    if (last_s) begin
                        out_root_r   <= chain_s.res;
                        out_rem_r    <= chain_s.eps[16:0];
                        out_cycles_r <= cnt_r + 5'd1;
                    end else begin
                        out_root_r   <= out_root_r;
                    end
                end
                S_DONE:  cnt_r <= cnt_r;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign busy       = busy_s;
    assign out_root   = out_root_r;
    assign out_rem    = out_rem_r;
    assign out_cycles = out_cycles_r;

endmodule
